tt_sweep_capture: RTL and testbench

//  Exhaustive stimulus/capture stage that sits directly upstream of a 4-input

---
 rtl/tt_sweep_pkg.sv | 16 +
 rtl/sat_counter.sv | 23 ++
 rtl/tt_sweep_capture.sv | 130 +++++++++++++
 tb/tb_tt_sweep_capture.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep/capture stage.
package tt_sweep_pkg;

  localparam int unsigned SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; holds at all-ones, cleared only by reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_sweep_capture.sv
// Drives every minterm into a small logic network, captures its output into a
// truth table and hands the result off on valid/ready with an expect-match flag.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int unsigned NUM_INPUTS    = 4,
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_i,
  input  logic [tt_width(NUM_INPUTS)-1:0]  expect_i,
  output logic                             busy_o,
  output logic [NUM_INPUTS-1:0]            x_o,
  input  logic                             y_i,
  output logic [tt_width(NUM_INPUTS)-1:0]  tt_o,
  output logic                             tt_valid_o,
  input  logic                             tt_ready_i,
  output logic                             match_o,
  output logic [ERR_W-1:0]                 err_cnt_o
);

  localparam int unsigned TT_W = tt_width(NUM_INPUTS);
  localparam logic [NUM_INPUTS-1:0] IDX_LAST   = NUM_INPUTS'(TT_W - 1);
  localparam logic [SETTLE_W-1:0]   SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);

  state_t                state_q;
  logic [NUM_INPUTS-1:0] idx_q;
  logic [SETTLE_W-1:0]   cnt_q;
  logic [TT_W-1:0]       exp_q;
  logic [TT_W-1:0]       tt_q;
  logic [TT_W-1:0]       tt_d;
  logic                  valid_q;
  logic                  match_q;
  logic                  busy_q;
  logic                  capture;
  logic                  last_cap;
  logic                  err_inc;

  // Capture strobe and the table as it will look after this cycle's sample.
  always_comb begin
    capture  = 1'b0;
    last_cap = 1'b0;
    tt_d     = tt_q;
    if ((state_q == SWEEP) && (cnt_q == SETTLE_MAX)) begin
      capture     = 1'b1;
      last_cap    = (idx_q == IDX_LAST);
      tt_d[idx_q] = y_i;
    end
    err_inc = last_cap && (tt_d != exp_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      valid_q <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= expect_i;
            tt_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        SWEEP: begin
          if (capture) begin
            tt_q  <= tt_d;
            cnt_q <= '0;
            idx_q <= idx_q + NUM_INPUTS'(1);
            if (last_cap) begin
              state_q <= DONE;
              valid_q <= 1'b1;
              match_q <= (tt_d == exp_q);
            end
          end else begin
            cnt_q <= cnt_q + SETTLE_W'(1);
          end
        end
        DONE: begin
          // A start coinciding with the handshake skips IDLE entirely.
          if (tt_ready_i) begin
            valid_q <= 1'b0;
            match_q <= 1'b0;
            if (start_i) begin
              state_q <= SWEEP;
              idx_q   <= '0;
              cnt_q   <= '0;
              exp_q   <= expect_i;
              tt_q    <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          match_q <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (err_inc),
    .cnt_o (err_cnt_o)
  );

  assign busy_o     = busy_q;
  assign x_o        = idx_q;
  assign tt_o       = tt_q;
  assign tt_valid_o = valid_q;
  assign match_o    = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Self-checking bench for tt_sweep_capture: vector table, corner sequences,
// randomized LUT networks checked against the truth-table-equals-function model.
module tb_tt_sweep_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Instance A: default parameters, network chosen by net_a
  logic        start_a, ready_a, y_a, busy_a, valid_a, match_a;
  logic [15:0] expect_a, tt_a, lut_a;
  logic [3:0]  x_a;
  logic [7:0]  err_a;
  logic [2:0]  net_a;

  // Instance B: SETTLE_CYCLES = 2, parity network with 2-cycle delay
  logic        start_b, ready_b, y_b, busy_b, valid_b, match_b;
  logic [15:0] expect_b, tt_b;
  logic [3:0]  x_b, d1_b, d2_b;
  logic [7:0]  err_b;

  // Instance C: NUM_INPUTS = 2, XOR network
  logic        start_c, ready_c, y_c, busy_c, valid_c, match_c;
  logic [3:0]  expect_c, tt_c;
  logic [1:0]  x_c;
  logic [7:0]  err_c;

  tt_sweep_capture u_dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .expect_i(expect_a), .busy_o(busy_a),
    .x_o(x_a), .y_i(y_a), .tt_o(tt_a), .tt_valid_o(valid_a), .tt_ready_i(ready_a),
    .match_o(match_a), .err_cnt_o(err_a));

  tt_sweep_capture #(.SETTLE_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .expect_i(expect_b), .busy_o(busy_b),
    .x_o(x_b), .y_i(y_b), .tt_o(tt_b), .tt_valid_o(valid_b), .tt_ready_i(ready_b),
    .match_o(match_b), .err_cnt_o(err_b));

  tt_sweep_capture #(.NUM_INPUTS(2)) u_dut_c (
    .clk(clk), .rst(rst), .start_i(start_c), .expect_i(expect_c), .busy_o(busy_c),
    .x_o(x_c), .y_i(y_c), .tt_o(tt_c), .tt_valid_o(valid_c), .tt_ready_i(ready_c),
    .match_o(match_c), .err_cnt_o(err_c));

  // Networks under test
  always_comb begin
    case (net_a)
      3'd0:    y_a = x_a[0] & x_a[1];
      3'd1:    y_a = (x_a[0] & x_a[1]) | (x_a[0] & x_a[2]) | (x_a[1] & x_a[2]);
      3'd2:    y_a = x_a[2] | x_a[3];
      3'd3:    y_a = ^x_a;
      default: y_a = lut_a[x_a];
    endcase
  end

  always @(posedge clk) begin
    d1_b <= x_b;
    d2_b <= d1_b;
  end
  assign y_b = ^d2_b;
  assign y_c = x_c[0] ^ x_c[1];

  int checks = 0;
  int failures = 0;
  int err_model = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Called on the negedge right after the start-accept edge.
  task automatic wait_result_a(output int lat, input bit noise);
    int cyc = 0;
    bit xok = 1'b1;
    while (!valid_a && cyc < 200) begin
      if (cyc < 16 && x_a != 4'(cyc)) xok = 1'b0;
      if (!busy_a) xok = 1'b0;
      if (noise) begin
        start_a  = 1'($urandom_range(0, 1));
        ready_a  = 1'($urandom_range(0, 1));
        expect_a = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b0;
    chk("x_sequence", 64'(xok), 64'd1);
    lat = cyc;
  endtask

  task automatic settle_result_a(input logic [15:0] tt_req, input logic match_req,
                                 input int hold, input string tag);
    logic [15:0] tt0;
    logic        m0;
    bit          stable = 1'b1;
    chk({tag, "_tt"}, 64'(tt_a), 64'(tt_req));
    chk({tag, "_match"}, 64'(match_a), 64'(match_req));
    if (!match_req) err_model = (err_model >= 255) ? 255 : err_model + 1;
    chk({tag, "_err"}, 64'(err_a), 64'(err_model));
    tt0 = tt_a;
    m0  = match_a;
    for (int i = 0; i < hold; i++) begin
      start_a = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (tt_a != tt0 || match_a != m0 || !valid_a || !busy_a) stable = 1'b0;
    end
    start_a = 1'b0;
    if (hold > 0) chk({tag, "_hold"}, 64'(stable), 64'd1);
  endtask

  task automatic run_a(input logic [2:0] net, input logic [15:0] lut, input logic [15:0] expv,
                       input logic [15:0] tt_req, input logic match_req, input int hold,
                       input bit noise, input string tag);
    int lat;
    net_a    = net;
    lut_a    = lut;
    expect_a = expv;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_result_a(lat, noise);
    chk({tag, "_latency"}, 64'(lat), 64'd16);
    settle_result_a(tt_req, match_req, hold, tag);
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk({tag, "_release"}, {62'd0, valid_a, busy_a}, 64'd0);
  endtask

  typedef struct {
    logic [2:0]  net;
    logic [15:0] lut;
    logic [15:0] expv;
    logic [15:0] tt;
    logic        match;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          lat;
    bit          xok;
    logic [15:0] lut;
    logic [15:0] expv;

    vecs[0] = '{3'd0, 16'h0000, 16'h8888, 16'h8888, 1'b1};
    vecs[1] = '{3'd1, 16'h0000, 16'hE8E8, 16'hE8E8, 1'b1};
    vecs[2] = '{3'd2, 16'h0000, 16'h0000, 16'hFFF0, 1'b0};
    vecs[3] = '{3'd3, 16'h0000, 16'h6996, 16'h6996, 1'b1};
    vecs[4] = '{3'd3, 16'h0000, 16'h6997, 16'h6996, 1'b0};
    vecs[5] = '{3'd4, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b1};

    rst = 1'b1;
    start_a = 0; ready_a = 0; expect_a = '0; lut_a = '0; net_a = '0;
    start_b = 0; ready_b = 0; expect_b = '0;
    start_c = 0; ready_c = 0; expect_c = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {32'd0, busy_a, x_a, tt_a, valid_a, match_a, err_a}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", {32'd0, busy_a, x_a, tt_a, valid_a, match_a, err_a}, 64'd0);

    // ready pulsed outside DONE must not disturb IDLE
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;
    chk("ready_in_idle", {62'd0, busy_a, valid_a}, 64'd0);

    foreach (vecs[i])
      run_a(vecs[i].net, vecs[i].lut, vecs[i].expv, vecs[i].tt, vecs[i].match, 2, 0, "vec");

    // Hold result 10 cycles with start ignored, then back-to-back restart
    net_a = 3'd3; expect_a = 16'h6996; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_result_a(lat, 0);
    chk("b2b_first_latency", 64'(lat), 64'd16);
    settle_result_a(16'h6996, 1'b1, 10, "b2b_first");
    ready_a = 1'b1; start_a = 1'b1; net_a = 3'd0; expect_a = 16'h8888;
    @(negedge clk);
    ready_a = 1'b0; start_a = 1'b0;
    chk("b2b_no_idle", {61'd0, busy_a, valid_a, 1'(x_a != 0)}, 64'b100);
    wait_result_a(lat, 0);
    chk("b2b_second_latency", 64'(lat), 64'd16);
    settle_result_a(16'h8888, 1'b1, 0, "b2b_second");
    ready_a = 1'b1;
    @(negedge clk);
    ready_a = 1'b0;

    // Repeated mismatching sweeps drive the error counter into saturation
    for (int i = 0; i < 300; i++) run_a(3'd2, 16'h0, 16'h0000, 16'hFFF0, 1'b0, 0, 0, "sat");
    chk("err_saturated", 64'(err_a), 64'hFF);

    // Reset in the middle of a sweep
    net_a = 3'd0; expect_a = 16'h8888; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_idx", 64'(x_a), 64'd7);
    rst = 1'b1;
    #1;
    chk("mid_reset_clear", {32'd0, busy_a, x_a, tt_a, valid_a, match_a, err_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    err_model = 0;
    @(negedge clk);
    run_a(3'd0, 16'h0, 16'h8888, 16'h8888, 1'b1, 0, 0, "post_reset");

    // Random lookup-table networks: captured table must equal the function itself
    for (int i = 0; i < 40; i++) begin
      lut  = 16'($urandom);
      expv = ($urandom_range(0, 1) != 0) ? lut : 16'($urandom);
      run_a(3'd4, lut, expv, lut, 1'(expv == lut), int'($urandom_range(0, 3)), 1, "rand");
    end

    // SETTLE_CYCLES = 2 with a delayed parity network
    expect_b = 16'h6996; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lat = 0; xok = 1'b1;
    while (!valid_b && lat < 400) begin
      if (lat < 48 && x_b != 4'(lat / 3)) xok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("settle_x_hold", 64'(xok), 64'd1);
    chk("settle_latency", 64'(lat), 64'd48);
    chk("settle_tt", 64'(tt_b), 64'h6996);
    chk("settle_match", {62'd0, match_b, busy_b}, 64'b11);
    ready_b = 1'b1;
    @(negedge clk);
    ready_b = 1'b0;

    // NUM_INPUTS = 2, XOR network
    expect_c = 4'h6; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    lat = 0;
    while (!valid_c && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("narrow_latency", 64'(lat), 64'd4);
    chk("narrow_tt", 64'(tt_c), 64'h6);
    chk("narrow_match", {62'd0, match_c, busy_c}, 64'b11);
    ready_c = 1'b1;
    @(negedge clk);
    ready_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
